// File: rtl/adex_synapse.sv
// rtl/adex_synapse.sv - delayed, weighted, exponentially decaying spike-to-current synapse; `define SYN_DECAY_ROUND_EN for round-half-up decay
module adex_synapse #(
    parameter int NO_OF_BITS = 24,
    parameter int N_IN       = 4,
    parameter int DELAY      = 3,
    parameter int TAU_SHIFT  = 4,
    localparam int AW        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_IN-1:0]              spike_in,
    input  logic                         w_we,
    input  logic [AW-1:0]                w_addr,
    input  logic signed [NO_OF_BITS-1:0] w_data,
    input  logic                         cnt_clr,
    output logic signed [NO_OF_BITS-1:0] I_syn,
    output logic                         sat,
    output logic [15:0]                  spike_cnt
);

    localparam int NB = NO_OF_BITS;
    // Headroom for N_IN full-scale weights plus the current and its decay term.
    localparam int EW = NO_OF_BITS + $clog2(N_IN) + 2;

    localparam logic signed [EW-1:0] I_MAX = {{(EW-NB+1){1'b0}}, {(NB-1){1'b1}}};
    localparam logic signed [EW-1:0] I_MIN = {{(EW-NB+1){1'b1}}, {(NB-1){1'b0}}};
`ifdef SYN_DECAY_ROUND_EN
    localparam logic signed [EW-1:0] RND   = {{(EW-1){1'b0}}, 1'b1} << (TAU_SHIFT - 1);
`endif

    logic signed [NB-1:0] weight_q [N_IN];
    logic signed [NB-1:0] I_q, I_d;
    logic                 sat_q, sat_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [N_IN-1:0]      d_out;

    logic signed [EW-1:0] sum_w;
    logic signed [EW-1:0] i_ext;
    logic signed [EW-1:0] decay;
    logic signed [EW-1:0] nxt;
    logic [16:0]          pop;
    logic [16:0]          cnt_sum;

    // Axonal delay: a DELAY-deep shift register of spike vectors that only advances on enabled steps.
    generate
        if (DELAY == 0) begin : g_nodly
            assign d_out = spike_in;
        end else begin : g_dly
            logic [N_IN-1:0] dly_q [DELAY];
            // Shift the spike vectors one stage per enabled step; reset drops anything in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
                end else if (en) begin
                    dly_q[0] <= spike_in;
                    for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign d_out = dly_q[DELAY-1];
        end
    endgenerate

    // Weight table; a delivery at the same edge still sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_IN; k++) weight_q[k] <= '0;
        end else if (w_we) begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_addr == AW'(k)) weight_q[k] <= w_data;
            end
        end
    end

    // Sum the weights of every delivered spike and count the events.
    always_comb begin
        sum_w = '0;
        pop   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (d_out[k]) begin
                sum_w = sum_w + {{(EW-NB){weight_q[k][NB-1]}}, weight_q[k]};
                pop   = pop + 17'd1;
            end
        end
    end

    // Leaky integration with clamping to the signed output range; counter saturates at all-ones.
    always_comb begin
        i_ext = {{(EW-NB){I_q[NB-1]}}, I_q};
`ifdef SYN_DECAY_ROUND_EN
        decay = (i_ext + RND) >>> TAU_SHIFT;
`else
        decay = i_ext >>> TAU_SHIFT;
`endif
        nxt     = i_ext - decay + sum_w;
        cnt_sum = {1'b0, cnt_q} + pop;
        I_d     = I_q;
        sat_d   = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            if (nxt > I_MAX) begin
                I_d   = I_MAX[NB-1:0];
                sat_d = 1'b1;
            end else if (nxt < I_MIN) begin
                I_d   = I_MIN[NB-1:0];
                sat_d = 1'b1;
            end else begin
                I_d   = nxt[NB-1:0];
            end
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
        if (cnt_clr) cnt_d = '0;
    end

    // Current, saturation flag and event counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            I_q   <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            I_q   <= I_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    assign I_syn     = I_q;
    assign sat       = sat_q;
    assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_adex_synapse.sv
// tb/tb_adex_synapse.sv - scoreboard bench for adex_synapse (default parameters)
module tb_adex_synapse;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [3:0]         spike_in;
    logic               w_we;
    logic [1:0]         w_addr;
    logic signed [23:0] w_data;
    logic               cnt_clr;
    logic signed [23:0] I_syn;
    logic               sat;
    logic [15:0]        spike_cnt;

    adex_synapse dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .cnt_clr   (cnt_clr),
        .I_syn     (I_syn),
        .sat       (sat),
        .spike_cnt (spike_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint i;
        bit     s;
        int     c;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    longint m_w [4];
    longint m_i;
    bit     m_sat;
    int     m_cnt;
    bit [3:0] m_dl [3];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_w[k] = 0;
        for (int k = 0; k < 3; k++) m_dl[k] = '0;
        m_i = 0; m_sat = 0; m_cnt = 0;
    endtask

    task automatic set_in(input bit e, input bit [3:0] s, input bit we, input bit [1:0] a,
                          input logic signed [23:0] d, input bit clr);
        en = e; spike_in = s; w_we = we; w_addr = a; w_data = d; cnt_clr = clr;
    endtask

    // Advance the reference model for the coming edge, push its prediction, clock, then pop and compare.
    task automatic tick(input string tag);
        exp_t   e;
        longint sum, dec, nxt;
        int     pc;
        bit [3:0] d;
        if (en) begin
            d = m_dl[2]; sum = 0; pc = 0;
            for (int k = 0; k < 4; k++) if (d[k]) begin sum += m_w[k]; pc++; end
`ifdef SYN_DECAY_ROUND_EN
            dec = (m_i + 8) >>> 4;
`else
            dec = m_i >>> 4;
`endif
            nxt = m_i - dec + sum;
            m_sat = 0;
            if (nxt > 8388607)       begin nxt = 8388607;  m_sat = 1; end
            else if (nxt < -8388608) begin nxt = -8388608; m_sat = 1; end
            m_i = nxt;
            m_dl[2] = m_dl[1]; m_dl[1] = m_dl[0]; m_dl[0] = spike_in;
        end else begin
            m_sat = 0;
            pc = 0;
        end
        if (cnt_clr) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + pc > 65535) ? 65535 : m_cnt + pc;
        if (w_we) m_w[w_addr] = w_data;
        e.i = m_i; e.s = m_sat; e.c = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, ".I"},   I_syn,     e.i);
        chk({tag, ".sat"}, sat,       e.s);
        chk({tag, ".cnt"}, spike_cnt, e.c);
    endtask

    task automatic idle(input string tag, input int n);
        set_in(1, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic wr(input bit [1:0] a, input logic signed [23:0] d);
        set_in(0, 4'b0000, 1, a, d, 0);
        tick("wr");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, ".rst_I"},   I_syn,     0);
        chk({tag, ".rst_sat"}, sat,       0);
        chk({tag, ".rst_cnt"}, spike_cnt, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 4'b0000, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        chk("init.I", I_syn, 0);
        chk("init.sat", sat, 0);
        chk("init.cnt", spike_cnt, 0);
        rst = 1'b1;

        // Single excitatory spike: latency and decay sequence.
        wr(0, 24'sh040000);
        set_in(1, 4'b0001, 0, 0, 0, 0);
        tick("t2.spk");
        idle("t2.wait", 2);
        chk("t2.before", I_syn, 0);
        idle("t2.dlv", 1);
        chk("t2.i0", I_syn, 24'sh040000);
        idle("t2.dec", 1);
        chk("t2.i1", I_syn, 24'sh03C000);
        idle("t2.dec", 1);
        chk("t2.i2", I_syn, 24'sh038400);
        chk("t2.cnt", spike_cnt, 1);

        // Reset with spikes in flight: nothing may surface afterwards.
        set_in(1, 4'b0001, 0, 0, 0, 0);
        tick("t1.spk");
        idle("t1.fly", 1);
        pulse_rst("t1");
        wr(0, 24'sh040000);
        idle("t1.after", 5);
        chk("t1.I", I_syn, 0);
        chk("t1.cnt", spike_cnt, 0);

        // Concurrent inhibitory plus excitatory spikes.
        pulse_rst("t3");
        wr(1, -24'sh100000);
        wr(2, 24'sh080000);
        set_in(1, 4'b0110, 0, 0, 0, 0);
        tick("t3.spk");
        idle("t3.wait", 3);
        chk("t3.I", I_syn, 24'shF80000);
        chk("t3.cnt", spike_cnt, 2);

        // Positive saturation, counter step of four, clear priority.
        pulse_rst("t4p");
        for (int k = 0; k < 4; k++) wr(2'(k), 24'sh600000);
        set_in(1, 4'b1111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("t4p.hold");
        chk("t4p.I", I_syn, 24'sh7FFFFF);
        chk("t4p.sat", sat, 1);
        chk("t4p.cnt4", spike_cnt, 4);
        tick("t4p.hold");
        chk("t4p.cnt8", spike_cnt, 8);
        set_in(1, 4'b1111, 0, 0, 0, 1);
        tick("t4p.clr");
        chk("t4p.clr", spike_cnt, 0);
        set_in(0, 4'b1111, 0, 0, 0, 0);
        tick("t4p.off");
        chk("t4p.sat_off", sat, 0);
        chk("t4p.hold_I", I_syn, 24'sh7FFFFF);

        // Negative saturation.
        pulse_rst("t4n");
        for (int k = 0; k < 4; k++) wr(2'(k), -24'sh600000);
        set_in(1, 4'b1111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("t4n.hold");
        chk("t4n.I", I_syn, 24'sh800000);
        chk("t4n.sat", sat, 1);

        // Write colliding with delivery uses the old weight; disabled spikes are dropped.
        pulse_rst("t5");
        wr(0, 24'sh020000);
        set_in(1, 4'b0001, 0, 0, 0, 0);
        tick("t5.spk");
        idle("t5.wait", 2);
        set_in(1, 4'b0000, 1, 0, 24'sh010000, 0);
        tick("t5.coll");
        chk("t5.coll", I_syn, 24'sh020000);
        set_in(0, 4'b1111, 0, 0, 0, 0);
        tick("t5.off");
        chk("t5.off_I", I_syn, 24'sh020000);
        chk("t5.off_cnt", spike_cnt, 1);
        idle("t5.after", 5);
        chk("t5.after_cnt", spike_cnt, 1);

        // Decay floor for a small positive current.
        pulse_rst("t6");
        wr(0, 24'sd15);
        set_in(1, 4'b0001, 0, 0, 0, 0);
        tick("t6.spk");
        idle("t6.wait", 3);
        chk("t6.i0", I_syn, 15);
        idle("t6.dec", 12);
`ifdef SYN_DECAY_ROUND_EN
        chk("t6.floor", I_syn, 7);
`else
        chk("t6.floor", I_syn, 15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adex_synapse.md
Name: adex_synapse

Overview:
Spike-to-current synapse: the receiving end of the neuron spike output. Takes N_IN presynaptic 1-bit spike lines, delays each by a fixed axonal delay, adds a programmable signed weight per delivered spike into an exponentially decaying current, and drives the signed current input of a downstream AdEx neuron. All values are signed Q4.20, the same format as the neuron's I input.

Parameters:
NO_OF_BITS, 24, width of weights and current (signed Q4.20)
N_IN, 4, number of presynaptic spike inputs (>=1)
DELAY, 3, axonal delay in clk cycles applied to every input (>=0)
TAU_SHIFT, 4, decay shift: I -= I>>>TAU_SHIFT per enabled cycle (1..15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
en  input  1  time-step enable; all state frozen when 0
spike_in  input  N_IN  presynaptic spike pulses, sampled only when en=1
w_we  input  1  weight write strobe (independent of en)
w_addr  input  clog2(N_IN) (min 1)  weight index; writes to addresses >= N_IN are ignored
w_data  input  NO_OF_BITS signed  weight value Q4.20
cnt_clr  input  1  synchronous clear of spike_cnt
I_syn  output  NO_OF_BITS signed  synaptic current, registered
sat  output  1  registered; high in the cycle after the update that clamped I_syn
spike_cnt  output  16  delivered spike events, saturating

Behaviour:
- Reset (rst=0, async): weights=0, delay line=0, I_syn=0, sat=0, spike_cnt=0. Reset mid-operation discards in-flight spikes.
- Delay line: DELAY-stage shift register of N_IN-bit vectors, advances only when en=1. d_out = spike_in delayed by DELAY enabled cycles. DELAY=0: d_out=spike_in combinationally.
- Weight write: on the edge with w_we=1, weight[w_addr] <= w_data. If a delivery uses the same address at that edge, the old weight is used. The new weight applies from the next edge.
- Sum: sum = Σ weight[k] over k with d_out[k]=1. Computed in NO_OF_BITS+clog2(N_IN)+2 bits, sign-extended, with no intermediate overflow.
- Update when en=1: nxt = I_syn - (I_syn>>>TAU_SHIFT) + sum, computed at full extended width.
  - Clamp to [-2^(NO_OF_BITS-1), 2^(NO_OF_BITS-1)-1].
  - I_syn <= clamped value; sat <= (clamp occurred).
- en=0: I_syn, delay line and spike_cnt hold; sat <= 0; spike_in ignored (dropped).
- Latency: spike at edge k (en held 1) is first visible on I_syn after edge k+DELAY+1.
- spike_cnt: when en=1, adds popcount(d_out) and saturates at 16'hFFFF (no wrap). cnt_clr=1 forces 0 and has priority over an increment at the same edge.
- Multiple simultaneous spikes on different inputs all sum in the same cycle. A spike held high for M enabled cycles counts as M events.

Optional Feature:
SYN_DECAY_ROUND_EN
- Defined: decay term = (I_syn + (1<<<(TAU_SHIFT-1)))>>>TAU_SHIFT, i.e. round-half-up. Small positive currents decay to below 2^(TAU_SHIFT-1).
- Undefined: decay term = I_syn>>>TAU_SHIFT (truncating arithmetic shift). Positive currents below 2^TAU_SHIFT LSB never decay.

Test Plan:
1. Reset check: assert rst=0 mid-run with spikes in flight, release -> I_syn=0, sat=0, spike_cnt=0, and no delayed spike ever appears on I_syn.
2. Single spike with defaults: w[0]=24'sh040000, en=1, one-cycle pulse spike_in=4'b0001 at edge 0 -> I_syn=24'sh040000 after edge 4, then 24'sh03C000, then 24'sh038400; spike_cnt=1.
3. Inhibitory plus concurrent spikes: w[1]=-24'sh100000, w[2]=24'sh080000, spike_in=4'b0110 for one cycle -> I_syn=24'shF80000 (-0.5) after edge 4; spike_cnt=2.
4. Saturation: all w=24'sh600000, spike_in=4'b1111 held -> I_syn=24'sh7FFFFF with sat=1 the following cycle; spike_cnt advances by 4 per cycle. Same test with negative weights -> I_syn=24'sh800000.
5. Write collision and en gating: w_we to addr 0 (new 24'sh010000) at the same edge as delivery with old w[0]=24'sh020000 -> increment is 24'sh020000. Pulse spike_in with en=0 -> no change to I_syn or spike_cnt.
6. Decay floor: preload I_syn=15 via w[0]=15 and a single spike, no further spikes -> stays 15 without the macro; decays 15,14,…,7 and holds at 7 with SYN_DECAY_ROUND_EN defined.
